// File: rtl/alu_drv_pkg.sv
// Shared definitions for the ALU command driver: default widths and FSM state encoding.
package alu_drv_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int SEL_W_DEF  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } drv_state_t;

endpackage

// File: rtl/alu_cmd_driver.sv
// Issues one command at a time to a registered ALU, waits its fixed latency,
// then returns the captured result with the command's tag.
//
// state | meaning
// IDLE  | ready for a command; alu_* bus holds the last issued operands
// WAIT  | operands on the ALU bus, counting down the ALU latency
// RESP  | response presented, held until rsp_ready
module alu_cmd_driver
  import alu_drv_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SEL_W   = SEL_W_DEF,
  parameter int TAG_W   = 4,
  parameter int ALU_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [SEL_W-1:0]  cmd_sel,
  input  logic              cmd_cin,
  input  logic              cmd_chain,
  input  logic [TAG_W-1:0]  cmd_tag,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  output logic              alu_cin,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_zero,
  output logic              busy
);

  if (ALU_LAT < 1 || ALU_LAT > 15) begin : g_lat_check
    $error("alu_cmd_driver: ALU_LAT=%0d outside legal range 1..15", ALU_LAT);
  end

  localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

  drv_state_t        r_state;
  logic [3:0]        r_cnt;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [SEL_W-1:0]  r_alu_sel;
  logic              r_alu_cin;
  logic [TAG_W-1:0]  r_tag;
  logic [DATA_W-1:0] r_last_result;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic [TAG_W-1:0]  r_rsp_tag;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_sel     <= '0;
      r_alu_cin     <= 1'b0;
      r_tag         <= '0;
      r_last_result <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_tag     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            // chaining reads the last captured result, not the alu_a bus
            r_alu_a   <= cmd_chain ? r_last_result : cmd_a;
            r_alu_b   <= cmd_b;
            r_alu_sel <= cmd_sel;
            r_alu_cin <= cmd_cin;
            r_tag     <= cmd_tag;
            r_cnt     <= CNT_INIT;
            r_state   <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_rsp_data    <= alu_result;
            r_last_result <= alu_result;
            r_rsp_tag     <= r_tag;
            r_rsp_valid   <= 1'b1;
            r_state       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_sel   = r_alu_sel;
  assign alu_cin   = r_alu_cin;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_tag   = r_rsp_tag;
  assign rsp_zero  = (r_rsp_data == '0);

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver paired with a registered-input ALU stub
// (sel 0: A+B+Cin, sel 1: A^B).
module tb_alu_cmd_driver;

  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_cin, cmd_chain;
  logic [7:0] cmd_a, cmd_b;
  logic [2:0] cmd_sel;
  logic [3:0] cmd_tag;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_sel;
  logic       alu_cin;
  logic       rsp_valid, rsp_ready, rsp_zero, busy;
  logic [7:0] rsp_data;
  logic [3:0] rsp_tag;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_cmd_driver #(.DATA_W(8), .SEL_W(3), .TAG_W(4), .ALU_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_cin(cmd_cin),
    .cmd_chain(cmd_chain), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_zero(rsp_zero), .busy(busy)
  );

  // ALU stub: inputs registered, result combinational from the registers
  logic [7:0] r_sa, r_sb;
  logic [2:0] r_ssel;
  logic       r_scin;
  always_ff @(posedge clk) begin
    r_sa   <= alu_a;
    r_sb   <= alu_b;
    r_ssel <= alu_sel;
    r_scin <= alu_cin;
  end
  always_comb begin
    alu_result = 8'h00;
    case (r_ssel)
      3'd0:    alu_result = r_sa + r_sb + {7'd0, r_scin};
      3'd1:    alu_result = r_sa ^ r_sb;
      default: alu_result = 8'h00;
    endcase
  end

  typedef struct {
    logic [7:0] a, b;
    logic [2:0] sel;
    logic       cin, chain;
    logic [3:0] tag;
    logic [7:0] exp_a, exp_data;
    logic       exp_zero;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input string nm, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] sel, input logic cin, input logic chain,
                       input logic [3:0] tag, input logic [7:0] exp_a);
    @(negedge clk);
    chk({nm, " cmd_ready"}, 32'(cmd_ready), 32'd1);
    cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_cin = cin; cmd_chain = chain; cmd_tag = tag;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk({nm, " alu_a"}, 32'(alu_a), 32'(exp_a));
    chk({nm, " alu_b"}, 32'(alu_b), 32'(b));
    chk({nm, " busy"}, 32'(busy), 32'd1);
  endtask

  task automatic wait_rsp(input string nm, input logic [7:0] exp_data,
                          input logic [3:0] exp_tag, input logic exp_zero);
    int lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({nm, " latency"}, 32'(lat), 32'(LAT));
    chk({nm, " rsp_data"}, 32'(rsp_data), 32'(exp_data));
    chk({nm, " rsp_tag"}, 32'(rsp_tag), 32'(exp_tag));
    chk({nm, " rsp_zero"}, 32'(rsp_zero), 32'(exp_zero));
  endtask

  task automatic handshake(input string nm);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk({nm, " rsp_valid drop"}, 32'(rsp_valid), 32'd0);
    chk({nm, " back to idle"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    vecs[0] = '{8'h12, 8'h34, 3'd0, 1'b1, 1'b0, 4'h5, 8'h12, 8'h47, 1'b0};
    vecs[1] = '{8'h10, 8'h05, 3'd0, 1'b0, 1'b0, 4'h1, 8'h10, 8'h15, 1'b0};
    vecs[2] = '{8'hFF, 8'h01, 3'd0, 1'b0, 1'b1, 4'h2, 8'h15, 8'h16, 1'b0};
    vecs[3] = '{8'hAA, 8'hAA, 3'd1, 1'b0, 1'b0, 4'h3, 8'hAA, 8'h00, 1'b1};
    vecs[4] = '{8'hFF, 8'h0F, 3'd1, 1'b1, 1'b1, 4'h4, 8'h00, 8'h0F, 1'b0};
    vecs[5] = '{8'hFF, 8'h01, 3'd0, 1'b0, 1'b0, 4'h6, 8'hFF, 8'h00, 1'b1};
    vecs[6] = '{8'h3C, 8'h80, 3'd0, 1'b1, 1'b1, 4'h7, 8'h00, 8'h81, 1'b0};

    rst = 1'b0; rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_a = 8'h77; cmd_b = 8'h66; cmd_sel = 3'd0;
    cmd_cin = 1'b1; cmd_chain = 1'b0; cmd_tag = 4'hF;

    // reset held with a command offered: nothing may be accepted
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst alu_a", 32'(alu_a), 32'd0);
      chk("rst rsp_zero", 32'(rsp_zero), 32'd1);
      chk("rst busy", 32'(busy), 32'd0);
    end
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post-rst idle", 32'(busy), 32'd0);

    for (int i = 0; i < 7; i++) begin
      string nm;
      nm = $sformatf("v%0d", i);
      issue(nm, vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].cin, vecs[i].chain,
            vecs[i].tag, vecs[i].exp_a);
      wait_rsp(nm, vecs[i].exp_data, vecs[i].tag, vecs[i].exp_zero);
      handshake(nm);
      chk({nm, " alu_a hold"}, 32'(alu_a), 32'(vecs[i].exp_a));
    end

    // backpressure: response must hold and new commands must be ignored
    issue("bp", 8'h01, 8'h02, 3'd0, 1'b0, 1'b0, 4'h9, 8'h01);
    wait_rsp("bp", 8'h03, 4'h9, 1'b0);
    cmd_a = 8'h55; cmd_b = 8'h11; cmd_tag = 4'hE; cmd_chain = 1'b0; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp rsp_data", 32'(rsp_data), 32'h03);
      chk("bp rsp_tag", 32'(rsp_tag), 32'h9);
      chk("bp cmd_ready", 32'(cmd_ready), 32'd0);
      chk("bp alu_a", 32'(alu_a), 32'h01);
    end
    cmd_valid = 1'b0;
    handshake("bp");
    @(posedge clk);
    #1;
    chk("bp no late accept", 32'(busy), 32'd0);

    // reset one edge after accept aborts the command
    issue("rw", 8'h20, 8'h22, 3'd0, 1'b0, 1'b0, 4'hA, 8'h20);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rw async busy", 32'(busy), 32'd0);
    chk("rw async alu_a", 32'(alu_a), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("rw no rsp", 32'(rsp_valid), 32'd0);
    end
    issue("rw chain", 8'hC3, 8'h07, 3'd0, 1'b0, 1'b1, 4'hB, 8'h00);
    wait_rsp("rw chain", 8'h07, 4'hB, 1'b0);
    handshake("rw chain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_cmd_driver.md
Name: alu_cmd_driver

Overview:
Command-side controller that feeds the registered 8-bit ALU top and collects its results.
- Accepts one ALU command at a time on a valid/ready channel.
- Drives registered operands, select and carry-in onto the ALU input bus, waits the ALU's fixed latency, then captures Result.
- Returns the result plus tag on a valid/ready response channel.
- Optional chaining reuses the previous result as operand A for accumulator-style sequences.

Parameters:
DATA_W, 8, operand/result width
SEL_W, 3, ALU select width
TAG_W, 4, command tag width, echoed on response
ALU_LAT, 2, rising edges from the edge that updates alu_* outputs to the edge that samples alu_result; legal range 1..15

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  driver can accept a command
cmd_a  input  DATA_W  operand A
cmd_b  input  DATA_W  operand B
cmd_sel  input  SEL_W  ALU operation select
cmd_cin  input  1  carry-in
cmd_chain  input  1  1: use last captured result as A, ignore cmd_a
cmd_tag  input  TAG_W  command tag
alu_a  output  DATA_W  to ALU A
alu_b  output  DATA_W  to ALU B
alu_sel  output  SEL_W  to ALU_Sel
alu_cin  output  1  to ALU Cin
alu_result  input  DATA_W  from ALU Result
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_data  output  DATA_W  captured result
rsp_tag  output  TAG_W  tag of the command that produced rsp_data
rsp_zero  output  1  rsp_data == 0
busy  output  1  FSM not in IDLE

Behaviour:
- Reset (rst low, async): state=IDLE; all of the following clear to 0 immediately, independent of clk:
  - alu_a, alu_b, alu_sel, alu_cin
  - rsp_valid, rsp_data, rsp_tag, busy
  - last_result, latency counter
- rsp_zero is 1 during reset because rsp_data=0. cmd_ready is 1 after reset because state=IDLE.
- Reset asserted mid-operation aborts the in-flight command. No response is ever produced for it.
- FSM states: IDLE, WAIT, RESP. All outputs are registered or decoded from state only; cmd_ready=(state==IDLE), busy=(state!=IDLE).
- IDLE:
  - On an edge with cmd_valid & cmd_ready:
    - alu_a <= cmd_chain ? last_result : cmd_a
    - alu_b <= cmd_b, alu_sel <= cmd_sel, alu_cin <= cmd_cin
    - tag register <= cmd_tag, cnt <= ALU_LAT-1, go WAIT.
  - cmd_valid with no acceptance has no effect.
- WAIT:
  - Each edge: if cnt!=0 then cnt <= cnt-1.
  - On the edge where cnt==0: rsp_data <= alu_result, last_result <= alu_result, rsp_tag <= tag register, rsp_valid <= 1, go RESP.
  - For ALU_LAT=1, capture occurs on the first edge after issue.
- RESP:
  - rsp_valid=1; rsp_data and rsp_tag stable until handshake.
  - On an edge with rsp_ready: rsp_valid <= 0, go IDLE.
- No command is accepted in RESP, so there is no same-edge response/command overlap.
- alu_* outputs hold their last values between commands. They do not return to 0.
- Latency: capture occurs ALU_LAT edges after the accept edge; rsp_valid rises on that edge.
- Throughput: one command per ALU_LAT+2 cycles with rsp_ready held high.
- Chain with no prior result since reset uses last_result=0.
- Chain always uses the most recently captured result, not the value currently on the alu_a bus.
- Widths: no arithmetic on data. The counter is 4 bits, and cnt underflow cannot occur.
- ALU_LAT outside 1..15 is a configuration error, checked by elaboration-time assertion.

Decomposition:
- Shared package alu_drv_pkg holds:
  - DATA_W and SEL_W defaults
  - FSM state encoding: IDLE=2'd0, WAIT=2'd1, RESP=2'd2
- Single module; no sub-module is natural. The latency counter is a few lines inside the FSM.
- Bench pairs the driver with the existing registered ALU top, or with a stub that has:
  - registered inputs
  - Result = A+B+Cin for sel 0, A^B for sel 1

Test Plan:
1. Reset: hold rst low 3 cycles with cmd_valid=1 -> cmd_ready=1, rsp_valid=0, alu_a=0, rsp_zero=1; no command accepted during reset.
2. Single add: cmd a=8'h12, b=8'h34, sel=0, cin=1, tag=5, ALU_LAT=2 -> rsp_valid rises 2 edges after accept; rsp_data=8'h47, rsp_tag=5, rsp_zero=0.
3. Chain: a=8'h10,b=8'h05,sel=0, then chain=1,b=8'h01,sel=0,cin=0 -> second alu_a=8'h15, rsp_data=8'h16.
4. Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_tag stable; cmd_ready=0; new cmd_valid ignored until handshake.
5. Zero/XOR: a=8'hAA, b=8'hAA, sel=1 -> rsp_data=8'h00, rsp_zero=1.
6. Reset mid-WAIT: assert rst one edge after accept -> rsp_valid never rises; next command after reset with chain=1 uses A=0.
